// File: rtl/fp_conv_core.sv
// fp_conv_core: registered conversion between two IEEE-754-style binary float
// formats. Rounding is round-to-nearest, ties-to-even.
//
// Parameters:
//   INX, INM : exponent width and stored-mantissa width of the input format
//   ONX, ONM : exponent width and stored-mantissa width of the output format
// Ports:
//   clk       : rising-edge clock
//   rst       : synchronous, active-high reset
//   in_valid  : in_value is valid this cycle
//   in_value  : {sign, exp[INX], man[INM]}
//   out_valid : in_valid delayed by one cycle
//   out_value : {sign, exp[ONX], man[ONM]}; held while no new input arrives
module fp_conv_core #(
  parameter int INX = 8,
  parameter int INM = 23,
  parameter int ONX = 8,
  parameter int ONM = 23
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [INX+INM:0] in_value,
  output logic             out_valid,
  output logic [ONX+ONM:0] out_value
);

  localparam int MW     = (INM > ONM) ? INM : ONM;
  localparam int SH_MAX = ONM + 2;              // any larger shift only feeds sticky
  localparam int TW     = MW + 1 + SH_MAX;
  localparam int EW     = 20;                   // covers 15-bit exponents plus 112-bit clz
  localparam int LZW    = $clog2(INM + 1) + 1;
  localparam int SHW    = $clog2(SH_MAX + 1) + 1;

  localparam logic signed [EW-1:0] BIAS_I    = EW'(2 ** (INX - 1) - 1);
  localparam logic signed [EW-1:0] BIAS_O    = EW'(2 ** (ONX - 1) - 1);
  localparam logic signed [EW-1:0] EXP_MAX_O = EW'(2 ** ONX - 1);
  localparam logic signed [EW-1:0] E_ONE     = EW'(1);
  localparam logic signed [EW-1:0] SH_MAX_E  = EW'(SH_MAX);

  function automatic logic [LZW-1:0] clz(input logic [INM-1:0] v);
    logic found;
    clz   = '0;
    found = 1'b0;
    for (int i = INM - 1; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      clz   = clz + LZW'(1);
      end
    end
  endfunction

  logic             in_sign;
  logic [INX-1:0]   in_exp;
  logic [INM-1:0]   in_man;
  assign {in_sign, in_exp, in_man} = in_value;

  logic                  exp_zero, exp_ones, man_zero;
  logic [LZW-1:0]        lz;
  logic [INM-1:0]        norm_man;
  logic signed [EW-1:0]  eo;
  logic signed [EW-1:0]  sh_full;
  logic [SHW-1:0]        sh;
  logic [MW:0]           sig;
  logic [TW-1:0]         ext;
  logic [ONM:0]          kept;
  logic                  guard, sticky;
  logic [ONM+1:0]        rnd;
  logic signed [EW-1:0]  exp_fin;
  logic [INM+ONM-1:0]    nan_ext;
  logic [ONM-1:0]        nan_man;
  logic [ONX+ONM:0]      res;

  always_comb begin
    exp_zero = (in_exp == '0);
    exp_ones = &in_exp;
    man_zero = (in_man == '0);
    lz       = clz(in_man);

    // Bring every finite input to 1.norm_man * 2^(eo - BIAS_O).
    if (exp_zero) begin
      norm_man = (in_man << lz) << 1;
      eo       = BIAS_O - BIAS_I - signed'(EW'(lz));
    end else begin
      norm_man = in_man;
      eo       = signed'(EW'(in_exp)) - BIAS_I + BIAS_O;
    end

    // Results below the output min normal are denormalised by a right shift.
    sh_full = E_ONE - eo;
    if (eo >= E_ONE)             sh = '0;
    else if (sh_full > SH_MAX_E) sh = SHW'(SH_MAX);
    else                         sh = sh_full[SHW-1:0];

    sig               = '0;
    sig[MW -: INM+1]  = {1'b1, norm_man};
    ext               = '0;
    ext[TW-1 -: MW+1] = sig;
    ext               = ext >> sh;

    kept   = ext[TW-1 -: ONM+1];
    guard  = ext[TW-ONM-2];
    sticky = |ext[TW-ONM-3:0];
    rnd    = {1'b0, kept} + (ONM+2)'(guard & (sticky | kept[0]));

    // A mantissa carry bumps the exponent; a subnormal that rounds up into
    // the hidden-bit position becomes the min normal (exp 1, man 0).
    if (eo >= E_ONE) exp_fin = eo + signed'(EW'(rnd[ONM+1]));
    else             exp_fin = signed'(EW'(rnd[ONM]));

    nan_ext = {in_man, ONM'(0)};
    nan_man = nan_ext[INM+ONM-1 -: ONM];
    nan_man[ONM-1] = 1'b1;

    if (exp_ones && man_zero)
      res = {in_sign, {ONX{1'b1}}, {ONM{1'b0}}};
    else if (exp_ones)
      res = {in_sign, {ONX{1'b1}}, nan_man};
    else if (exp_zero && man_zero)
      res = {in_sign, {ONX{1'b0}}, {ONM{1'b0}}};
    else if (exp_fin >= EXP_MAX_O)
      res = {in_sign, {ONX{1'b1}}, {ONM{1'b0}}};
    else
      res = {in_sign, exp_fin[ONX-1:0], rnd[ONM-1:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_value <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) out_value <= res;
    end
  end

endmodule

// File: tb/tb_fp_conv_core.sv
// tb_fp_conv_core: directed vectors for single<->double conversion, an
// identity instance, and a widen-then-narrow chain fed with random floats.
module tb_fp_conv_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_n;
  logic [63:0] in_w;

  logic        vld_w, vld_n, vld_i, vld_rt;
  logic [63:0] out_w;
  logic [31:0] out_n, out_i, out_rt;

  always #5 clk = ~clk;

  // single -> double
  fp_conv_core #(.INX(8), .INM(23), .ONX(11), .ONM(52)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_value(in_n),
    .out_valid(vld_w), .out_value(out_w));

  // double -> single
  fp_conv_core #(.INX(11), .INM(52), .ONX(8), .ONM(23)) dut_n (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_value(in_w),
    .out_valid(vld_n), .out_value(out_n));

  // single -> single
  fp_conv_core #(.INX(8), .INM(23), .ONX(8), .ONM(23)) dut_i (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_value(in_n),
    .out_valid(vld_i), .out_value(out_i));

  // double -> single, fed by dut_w
  fp_conv_core #(.INX(11), .INM(52), .ONX(8), .ONM(23)) dut_rt (
    .clk(clk), .rst(rst), .in_valid(vld_w), .in_value(out_w),
    .out_valid(vld_rt), .out_value(out_rt));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] n_in;
    logic [63:0] w_exp;
    logic [31:0] i_exp;
    logic [63:0] w_in;
    logic [31:0] n_exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] prev;
    logic [31:0] v;

    vecs.push_back('{32'h3F800000, 64'h3FF0000000000000, 32'h3F800000, 64'h3FF0000010000000, 32'h3F800000});
    vecs.push_back('{32'h80000000, 64'h8000000000000000, 32'h80000000, 64'h3FF0000030000000, 32'h3F800002});
    vecs.push_back('{32'h00000001, 64'h36A0000000000000, 32'h00000001, 64'h7E37E43C8800759C, 32'h7F800000});
    vecs.push_back('{32'h7FC00000, 64'h7FF8000000000000, 32'h7FC00000, 64'hFFF0000000000000, 32'hFF800000});
    vecs.push_back('{32'hC0490FDB, 64'hC00921FB60000000, 32'hC0490FDB, 64'h36A0000000000000, 32'h00000001});
    vecs.push_back('{32'h7F800000, 64'h7FF0000000000000, 32'h7F800000, 64'h3690000000000000, 32'h00000000});
    vecs.push_back('{32'hFF800000, 64'hFFF0000000000000, 32'hFF800000, 64'hB690000000000001, 32'h80000001});
    vecs.push_back('{32'h7F800001, 64'h7FF8000020000000, 32'h7FC00001, 64'h47EFFFFFF0000000, 32'h7F800000});
    vecs.push_back('{32'h007FFFFF, 64'h380FFFFFC0000000, 32'h007FFFFF, 64'h380FFFFFF0000000, 32'h00800000});
    vecs.push_back('{32'h7F7FFFFF, 64'h47EFFFFFE0000000, 32'h7F7FFFFF, 64'h47EFFFFFE0000000, 32'h7F7FFFFF});
    vecs.push_back('{32'h00800000, 64'h3810000000000000, 32'h00800000, 64'hFFF4000000000000, 32'hFFE00000});
    vecs.push_back('{32'h00000000, 64'h0000000000000000, 32'h00000000, 64'h7FF0000000000001, 32'h7FC00000});
    vecs.push_back('{32'h40000000, 64'h4000000000000000, 32'h40000000, 64'h3FF0000008000000, 32'h3F800000});
    vecs.push_back('{32'h3E800000, 64'h3FD0000000000000, 32'h3E800000, 64'h3FF0000018000000, 32'h3F800001});
    vecs.push_back('{32'hBF800000, 64'hBFF0000000000000, 32'hBF800000, 64'h3FF00000F0000000, 32'h3F800008});

    // Reset with valid input present: the input must be discarded.
    rst      = 1'b1;
    in_valid = 1'b1;
    in_n     = 32'h3F800000;
    in_w     = 64'h3FF0000000000000;
    step();
    check_val("rst_vld_w", 64'(vld_w), 64'd0);
    check_val("rst_val_w", out_w, 64'd0);
    check_val("rst_vld_n", 64'(vld_n), 64'd0);
    check_val("rst_val_n", 64'(out_n), 64'd0);
    step();
    rst = 1'b0;

    // Directed vectors; dut_rt lags by one cycle.
    for (int k = 0; k < vecs.size(); k++) begin
      in_valid = 1'b1;
      in_n     = vecs[k].n_in;
      in_w     = vecs[k].w_in;
      step();
      check_val($sformatf("w_vld%0d", k), 64'(vld_w), 64'd1);
      check_val($sformatf("w%0d", k), out_w, vecs[k].w_exp);
      check_val($sformatf("n%0d", k), 64'(out_n), 64'(vecs[k].n_exp));
      check_val($sformatf("i%0d", k), 64'(out_i), 64'(vecs[k].i_exp));
      if (k > 0) check_val($sformatf("rt%0d", k), 64'(out_rt), 64'(vecs[k-1].i_exp));
    end

    // No new input: outputs hold, out_valid drops.
    in_valid = 1'b0;
    in_n     = 32'h12345678;
    in_w     = 64'h0000000000000001;
    step();
    check_val("hold_vld_w", 64'(vld_w), 64'd0);
    check_val("hold_w", out_w, 64'hBFF0000000000000);
    check_val("hold_n", 64'(out_n), 64'h3F800008);
    check_val("hold_i", 64'(out_i), 64'hBF800000);
    check_val("hold_rt_vld", 64'(vld_rt), 64'd1);
    check_val("hold_rt", 64'(out_rt), 64'hBF800000);
    step();
    check_val("hold_rt_vld2", 64'(vld_rt), 64'd0);
    check_val("hold_rt2", 64'(out_rt), 64'hBF800000);

    // Random non-NaN singles: identity and widen/narrow round trip.
    prev = '0;
    for (int i = 0; i < 300; i++) begin
      v = $urandom;
      if (v[30:23] == 8'hFF) v[30:23] = 8'hFE;
      if (i % 4 == 0)        v[30:23] = 8'h00;
      in_valid = 1'b1;
      in_n     = v;
      step();
      check_val($sformatf("rand_i%0d", i), 64'(out_i), 64'(v));
      if (i > 0) check_val($sformatf("rand_rt%0d", i), 64'(out_rt), 64'(prev));
      prev = v;
    end

    // Reset mid-stream drops the in-flight result.
    in_n = 32'h3F800000;
    rst  = 1'b1;
    step();
    check_val("mid_rst_vld", 64'(vld_w), 64'd0);
    check_val("mid_rst_val", out_w, 64'd0);
    rst  = 1'b0;
    in_n = 32'h80000000;
    step();
    check_val("post_rst_vld", 64'(vld_w), 64'd1);
    check_val("post_rst_val", out_w, 64'h8000000000000000);
    check_val("post_rst_rt_vld", 64'(vld_rt), 64'd0);
    in_valid = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fp_conv_core.md
FP_CONV_CORE -- requirements
Module: fp_conv

Interface
REQ-001 SHALL have parameter INX, default 8, input exponent width.
REQ-002 SHALL have parameter INM, default 23, input stored-mantissa width.
REQ-003 SHALL have parameter ONX, default 8, output exponent width.
REQ-004 SHALL have parameter ONM, default 23, output stored-mantissa width.
REQ-005 SHALL have port clk  input  1  rising-edge clock; only clock, all state on this edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port in_valid  input  1  in_value valid this cycle.
REQ-008 SHALL have port in_value  input  INX+INM+1  source float, {sign, exp[INX], man[INM]}.
REQ-009 SHALL have port out_valid  output  1  out_value holds a converted result.
REQ-010 SHALL have port out_value  output  ONX+ONM+1  converted float, {sign, exp[ONX], man[ONM]}.

Function
REQ-011 SHALL treat both formats as IEEE-754-style: bias 2^(NX-1)-1, hidden leading 1 for normals, exp all-zero = zero/subnormal, exp all-ones = Inf/NaN.
REQ-012 SHALL register the result: out_value/out_valid reflect the in_value/in_valid sampled at the previous clk edge, 1-cycle latency, throughput 1 per cycle, no backpressure.
REQ-013 SHALL hold out_value unchanged in cycles where in_valid was 0; out_valid follows in_valid delayed by one cycle.
REQ-014 SHALL copy the sign bit unchanged in every case, including zero, Inf, NaN.
REQ-015 SHALL map ±0 to ±0 and ±Inf to ±Inf.
REQ-016 SHALL map any NaN to a quiet NaN: exp all-ones, mantissa MSB forced 1, remaining bits = top input payload bits, left-aligned, truncated or zero-padded.
REQ-017 SHALL normalise subnormal inputs with an internal count-leading-zeros of the INM-bit mantissa and rebias the exponent accordingly.
REQ-018 SHALL, when output precision and range cover the input, produce the exact value; identical parameters SHALL yield out_value == in_value bit-for-bit for all non-NaN inputs.
REQ-019 SHALL round to nearest, ties to even, when ONM < INM or the result falls in the output subnormal range.
REQ-020 SHALL produce output subnormals (exp 0) for magnitudes below the output min normal, correctly rounded; values rounding below half the min subnormal SHALL become signed zero.
REQ-021 SHALL produce signed Inf when the rounded magnitude exceeds the output max finite value, including when rounding carries into exponent all-ones.
REQ-022 SHALL renormalise a rounding carry out of the mantissa by incrementing the exponent; subnormal rounding up to min normal SHALL give exp 1, mantissa 0.
REQ-023 SHALL guarantee round-trip: narrow->wide->narrow conversion returns the original bit pattern for every non-NaN value.
REQ-024 SHALL support any widths with INX,ONX in 2..15 and INM,ONM in 1..112; intermediate exponent arithmetic signed and wide enough to avoid overflow.

Reset
REQ-025 SHALL, while rst is high at a clk edge, set out_valid=0 and out_value=0; in_value sampled that cycle is discarded.
REQ-026 SHALL, on reset asserted mid-stream, drop the in-flight result; first valid output appears one cycle after the first in_valid sampled with rst low.

Verification
REQ-027 SHALL pass: (8,23)->(11,52), in 0x3F800000 -> out 0x3FF0000000000000 one cycle later with out_valid=1.
REQ-028 SHALL pass: (11,52)->(8,23), in 0x3FF0000010000000 (1+2^-24 tie) -> 0x3F800000; in 0x3FF0000030000000 -> 0x3F800002.
REQ-029 SHALL pass: (11,52)->(8,23), in 0x7E37E43C8800759C (1e300) -> 0x7F800000; in 0xFFF0000000000000 -> 0xFF800000.
REQ-030 SHALL pass: (8,23)->(11,52), subnormal 0x00000001 -> 0x36A0000000000000; NaN 0x7FC00000 -> 0x7FF8000000000000.
REQ-031 SHALL pass: 100000 random finite values in ±1e4, (11,52)->(8,23)->(11,52)->(8,23) identical to first narrowed value, and (8,23)->(8,23) identity.
REQ-032 SHALL pass: rst high with in_valid=1 -> out_valid=0, out_value=0 next cycle; rst low then in 0x80000000 -> out 0x8000000000000000 for (8,23)->(11,52).
